ccip_avmm_mmio_bridge: RTL
==========================

// Module: ccip_avmm_mmio_bridge
// PURPOSE
// - Parametrised MMIO command bridge: buffers decoded CCI-P MMIO commands (t_ccip_avmm_mmio_cmd fields + tid),
//   issues them as Avalon-MM master reads/writes, returns read data tagged with the original tid.
// - Sits between the CCI-P MMIO decoder and the AFU Avalon CSR fabric; adds command queueing, multiple
//   outstanding reads, 32/64-bit lane steering and an optional read timeout.
// PARAMETERS
// - ADDR_WIDTH      18  Avalon byte-address width (CCIP_AVMM_MMIO_ADDR_WIDTH)
// - DATA_WIDTH      64  data width; only 64 is legal (elaboration $error otherwise)
// - TID_WIDTH       9   CCI-P MMIO transaction id width
// - CMD_DEPTH       8   command FIFO depth, power of 2, >=2
// - MAX_RD_OUTST    4   max outstanding Avalon reads (tracking FIFO depth), power of 2
// - TIMEOUT_CYCLES  512 read timeout, only used with CCIP_AVMM_MMIO_TIMEOUT_EN
// PORTS
// - clk              in   1              clock
// - reset_n          in   1              async active-low reset
// - cmd_valid        in   1              command present
// - cmd_ready        out  1              command accepted when valid&ready
// - cmd_is_read      in   1              1=read, 0=write
// - cmd_is_32bit     in   1              1=32-bit access, 0=64-bit
// - cmd_addr         in   ADDR_WIDTH     byte address
// - cmd_wdata        in   DATA_WIDTH     write data (32-bit data in [31:0])
// - cmd_tid          in   TID_WIDTH      read tid (ignored for writes)
// - avm_address      out  ADDR_WIDTH     byte address, bits [2:0] forced 0
// - avm_read/avm_write out 1             Avalon request strobes (never both)
// - avm_writedata    out  DATA_WIDTH     write data
// - avm_byteenable   out  DATA_WIDTH/8   byte enables
// - avm_waitrequest  in   1              slave stall
// - avm_readdata     in   DATA_WIDTH     read data
// - avm_readdatavalid in  1              read data strobe, in request order
// - rsp_valid        out  1              one-cycle read response pulse, no backpressure
// - rsp_tid          out  TID_WIDTH      tid of response
// - rsp_data         out  DATA_WIDTH     response data
// - rd_timeout       out  1              one-cycle pulse on timeout (0 when macro absent)
// BEHAVIOUR
// - Reset: all outputs 0 incl. cmd_ready; FIFOs, counters cleared. cmd_ready rises first clk after release.
// - cmd_ready registered = (cmd count < CMD_DEPTH) next cycle; push when full impossible; push+pop same cycle
//   keeps count; FIFO pointers wrap modulo CMD_DEPTH.
// - Issue: head entry drives avm_* from cycle after acceptance (min 1-cycle latency). Outputs held stable while
//   avm_waitrequest=1; entry popped on cycle request sampled with waitrequest=0.
// - Read issued only if tracking FIFO not full; writes never wait on outstanding reads (program order kept).
// - Tracking FIFO stores {tid, is_32bit, addr[2]} per issued read; popped on readdatavalid.
// - Lanes: 64-bit -> be=8'hFF. 32-bit -> be = addr[2] ? 8'hF0 : 8'h0F, writedata = {2{wdata[31:0]}}.
//   32-bit read rsp_data = {2{selected 32-bit lane}}.
// - Response: readdatavalid cycle M -> rsp_valid/tid/data registered at M+1.
// - readdatavalid with empty tracking FIFO (stray, e.g. after reset mid-read) is dropped silently.
// - Reset mid-operation: queued commands and outstanding tracking discarded; no responses emitted.
// CONFIGURATION
// - `CCIP_AVMM_MMIO_TIMEOUT_EN defined: counter runs while tracking FIFO non-empty, restarts on each pop.
//   At TIMEOUT_CYCLES: pop head, rsp_valid with rsp_data all-ones and its tid, rd_timeout pulse,
//   increment drop counter; next drop-counter readdatavalids discarded (counter decrements).
//   Timeout and readdatavalid same cycle: real data wins, no timeout.
// - Undefined: no counter; reads wait indefinitely; rd_timeout tied 0.
// TESTING
// - 64-bit write addr 0x100 data 0x1122334455667788 -> avm_write, address 0x100, be 0xFF, data unchanged.
// - 32-bit write addr 0x104 data 0xCAFEBABE -> be 0xF0, writedata 0xCAFEBABECAFEBABE.
// - 32-bit read addr 0x0C tid 0x5, readdata 0xAAAAAAAA_BBBBBBBB -> rsp tid 0x5, data 0xAAAAAAAAAAAAAAAA.
// - 6 reads, no readdatavalid -> exactly 4 issued, 5th held; one readdatavalid -> 5th issues next cycle.
// - waitrequest=1 for 10 cycles, 8 commands pushed -> cmd_ready=0 after 8th, avm_* stable, then drain in order.
// - TIMEOUT_EN, read tid 0x1A never answered -> at 512 cycles rsp tid 0x1A data all-ones, rd_timeout=1;
//   late readdatavalid dropped, no rsp_valid.

Source files
------------

// File: rtl/ccip_avmm_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ccip_avmm_mmio_bridge
// Description : Buffers decoded CCI-P MMIO commands, issues them as Avalon-MM
//               master reads/writes with 32/64-bit lane steering, and returns
//               read data tagged with the originating CCI-P tid. Multiple reads
//               may be outstanding; responses return in request order.
// Option      : define CCIP_AVMM_MMIO_TIMEOUT_EN to enable the read timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (ready is registered)
//   cmd_is_read, cmd_is_32bit command type and access size
//   cmd_addr, cmd_wdata       byte address, write data (32-bit data in [31:0])
//   cmd_tid                   read transaction id
//   avm_*                     Avalon-MM master (address, read, write,
//                             writedata, byteenable, waitrequest, readdata,
//                             readdatavalid)
//   rsp_valid/rsp_tid/rsp_data read response pulse, no backpressure
//   rd_timeout                one-cycle pulse when a read is abandoned
// ============================================================================
module ccip_avmm_mmio_bridge #(
    parameter int ADDR_WIDTH     = 18,
    parameter int DATA_WIDTH     = 64,
    parameter int TID_WIDTH      = 9,
    parameter int CMD_DEPTH      = 8,
    parameter int MAX_RD_OUTST   = 4,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_is_read,
    input  logic                    cmd_is_32bit,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [TID_WIDTH-1:0]    cmd_tid,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [DATA_WIDTH-1:0]   avm_writedata,
    output logic [DATA_WIDTH/8-1:0] avm_byteenable,
    input  logic                    avm_waitrequest,
    input  logic [DATA_WIDTH-1:0]   avm_readdata,
    input  logic                    avm_readdatavalid,
    output logic                    rsp_valid,
    output logic [TID_WIDTH-1:0]    rsp_tid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rd_timeout
);

    generate
        if (DATA_WIDTH != 64) begin : g_bad_data_width
            $error("ccip_avmm_mmio_bridge: DATA_WIDTH must be 64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Command FIFO: {is_read, is_32bit, addr[ADDR_WIDTH-1:2], wdata, tid}
    // ------------------------------------------------------------------
    localparam int c_CMD_AW = $clog2(CMD_DEPTH);
    localparam int c_CMD_W  = 2 + (ADDR_WIDTH - 2) + DATA_WIDTH + TID_WIDTH;
    localparam logic [c_CMD_AW:0] c_CMD_FULL = (c_CMD_AW + 1)'(CMD_DEPTH);

    logic [c_CMD_W-1:0]    r_cmd_mem [CMD_DEPTH];
    logic [c_CMD_AW-1:0]   r_cmd_wr_ptr;
    logic [c_CMD_AW-1:0]   r_cmd_rd_ptr;
    logic [c_CMD_AW:0]     r_cmd_cnt;
    logic [c_CMD_AW:0]     w_cmd_cnt_nxt;
    logic                  r_cmd_ready;
    logic                  w_cmd_push;
    logic                  w_cmd_pop;
    logic                  w_h_valid;
    logic                  w_h_read;
    logic                  w_h_32;
    logic [ADDR_WIDTH-3:0] w_h_addr;
    logic [DATA_WIDTH-1:0] w_h_wdata;
    logic [TID_WIDTH-1:0]  w_h_tid;
    logic                  w_issue;
    logic                  w_unused_addr_lsbs;

    // Sub-word address bits carry no information for 32/64-bit accesses.
    assign w_unused_addr_lsbs = &{1'b0, cmd_addr[1:0]};

    assign cmd_ready  = r_cmd_ready;
    assign w_cmd_push = cmd_valid & r_cmd_ready;
    assign w_h_valid  = (r_cmd_cnt != '0);
    assign {w_h_read, w_h_32, w_h_addr, w_h_wdata, w_h_tid} = r_cmd_mem[r_cmd_rd_ptr];

    always_comb begin
        w_cmd_cnt_nxt = r_cmd_cnt;
        if (w_cmd_push && !w_cmd_pop) begin
            w_cmd_cnt_nxt = r_cmd_cnt + (c_CMD_AW + 1)'(1);
        end else if (!w_cmd_push && w_cmd_pop) begin
            w_cmd_cnt_nxt = r_cmd_cnt - (c_CMD_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wr_ptr] <= {cmd_is_read, cmd_is_32bit,
                                        cmd_addr[ADDR_WIDTH-1:2], cmd_wdata, cmd_tid};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_wr_ptr <= '0;
            r_cmd_rd_ptr <= '0;
            r_cmd_cnt    <= '0;
            r_cmd_ready  <= 1'b0;
        end else begin
            if (w_cmd_push) r_cmd_wr_ptr <= r_cmd_wr_ptr + c_CMD_AW'(1);
            if (w_cmd_pop)  r_cmd_rd_ptr <= r_cmd_rd_ptr + c_CMD_AW'(1);
            r_cmd_cnt   <= w_cmd_cnt_nxt;
            r_cmd_ready <= (w_cmd_cnt_nxt < c_CMD_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Tracking FIFO for issued reads: {tid, is_32bit, addr[2]}
    // ------------------------------------------------------------------
    localparam int c_TRK_AW = (MAX_RD_OUTST > 1) ? $clog2(MAX_RD_OUTST) : 1;
    localparam int c_TRK_W  = TID_WIDTH + 2;
    localparam logic [c_TRK_AW:0]   c_TRK_FULL = (c_TRK_AW + 1)'(MAX_RD_OUTST);
    localparam logic [c_TRK_AW-1:0] c_TRK_LAST = c_TRK_AW'(MAX_RD_OUTST - 1);

    logic [c_TRK_W-1:0]   r_trk_mem [MAX_RD_OUTST];
    logic [c_TRK_AW-1:0]  r_trk_wr_ptr;
    logic [c_TRK_AW-1:0]  r_trk_rd_ptr;
    logic [c_TRK_AW:0]    r_trk_cnt;
    logic                 w_trk_push;
    logic                 w_trk_pop;
    logic                 w_trk_full;
    logic                 w_trk_nonempty;
    logic [TID_WIDTH-1:0] w_t_tid;
    logic                 w_t_32;
    logic                 w_t_addr2;
    logic [31:0]          w_lane;
    logic                 w_rdv_take;
    logic                 w_timeout;

    assign w_trk_full     = (r_trk_cnt == c_TRK_FULL);
    assign w_trk_nonempty = (r_trk_cnt != '0);
    assign w_trk_push     = avm_read & ~avm_waitrequest;
    assign w_trk_pop      = w_rdv_take | w_timeout;
    assign {w_t_tid, w_t_32, w_t_addr2} = r_trk_mem[r_trk_rd_ptr];
    assign w_lane = w_t_addr2 ? avm_readdata[DATA_WIDTH-1:32] : avm_readdata[31:0];

    always_ff @(posedge clk) begin
        if (w_trk_push) begin
            r_trk_mem[r_trk_wr_ptr] <= {w_h_tid, w_h_32, w_h_addr[0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trk_wr_ptr <= '0;
            r_trk_rd_ptr <= '0;
            r_trk_cnt    <= '0;
        end else begin
            if (w_trk_push) begin
                r_trk_wr_ptr <= (r_trk_wr_ptr == c_TRK_LAST) ? '0 : r_trk_wr_ptr + c_TRK_AW'(1);
            end
            if (w_trk_pop) begin
                r_trk_rd_ptr <= (r_trk_rd_ptr == c_TRK_LAST) ? '0 : r_trk_rd_ptr + c_TRK_AW'(1);
            end
            if (w_trk_push && !w_trk_pop) begin
                r_trk_cnt <= r_trk_cnt + (c_TRK_AW + 1)'(1);
            end else if (!w_trk_push && w_trk_pop) begin
                r_trk_cnt <= r_trk_cnt - (c_TRK_AW + 1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Avalon issue. Head entry is presented until accepted; reads wait for
    // tracking space, writes never wait. While a read is stalled the
    // tracking count can only fall, so avm_read cannot drop mid-stall.
    // ------------------------------------------------------------------
    assign avm_read    = w_h_valid & w_h_read & ~w_trk_full;
    assign avm_write   = w_h_valid & ~w_h_read;
    assign w_issue     = avm_read | avm_write;
    assign w_cmd_pop   = w_issue & ~avm_waitrequest;
    assign avm_address = w_issue ? {w_h_addr[ADDR_WIDTH-3:1], 3'b000} : '0;

    always_comb begin
        avm_byteenable = '0;
        avm_writedata  = '0;
        if (w_issue) begin
            if (w_h_32) avm_byteenable = w_h_addr[0] ? 8'hF0 : 8'h0F;
            else        avm_byteenable = 8'hFF;
        end
        if (avm_write) begin
            avm_writedata = w_h_32 ? {2{w_h_wdata[31:0]}} : w_h_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read timeout
    // ------------------------------------------------------------------
`ifdef CCIP_AVMM_MMIO_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic [15:0]       r_drop_cnt;
    logic              r_rd_timeout;
    logic              w_drop;

    // Data for an abandoned read still arrives in order; it is absorbed
    // by the drop counter ahead of any live tracking entry.
    assign w_drop     = avm_readdatavalid & (r_drop_cnt != '0);
    assign w_rdv_take = avm_readdatavalid & ~w_drop & w_trk_nonempty;
    // Any readdatavalid in the expiry cycle defers the timeout.
    assign w_timeout  = w_trk_nonempty & ~avm_readdatavalid & (r_to_cnt == c_TO_LAST);
    assign rd_timeout = r_rd_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt     <= '0;
            r_drop_cnt   <= '0;
            r_rd_timeout <= 1'b0;
        end else begin
            r_rd_timeout <= w_timeout;
            if (!w_trk_nonempty || w_trk_pop) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_TO_LAST) begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
            if (w_timeout && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end else if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - 16'd1;
            end
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    // Stray readdatavalid with nothing tracked is simply ignored.
    assign w_rdv_take = avm_readdatavalid & w_trk_nonempty;
    assign w_timeout  = 1'b0;
    assign rd_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    logic                  r_rsp_valid;
    logic [TID_WIDTH-1:0]  r_rsp_tid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    assign rsp_valid = r_rsp_valid;
    assign rsp_tid   = r_rsp_tid;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tid   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_trk_pop;
            if (w_rdv_take) begin
                r_rsp_tid  <= w_t_tid;
                r_rsp_data <= w_t_32 ? {2{w_lane}} : avm_readdata;
            end else if (w_timeout) begin
                r_rsp_tid  <= w_t_tid;
                r_rsp_data <= '1;
            end
        end
    end

endmodule
`default_nettype wire
